ingreso_vc: RTL and testbench

//   Ingress stage directly upstream of the qos block. Holds one pending word per

---
 rtl/ingreso_vc.sv | 121 ++++++++++++
 tb/tb_ingreso_vc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ingreso_vc.sv
// Ingress stage in front of qos: one holding slot per virtual channel, round-robin
// serialisation of pending words, per-VC pause tracking and a saturating error_full counter.
module ingreso_vc #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int BUF_WIDTH      = 3,
  parameter int ERR_CNT_BITS   = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enb,
  input  logic [QUEUE_QUANTITY-1:0]               src_valid,
  input  logic [QUEUE_QUANTITY*(BUF_WIDTH+1)-1:0] src_data,
  output logic [QUEUE_QUANTITY-1:0]               src_ready,
  input  logic [QUEUE_QUANTITY-1:0]               pausa,
  input  logic [QUEUE_QUANTITY-1:0]               continuar,
  input  logic [QUEUE_QUANTITY-1:0]               error_full,
  output logic                                    push,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]       vc_id,
  output logic [BUF_WIDTH:0]                      data_word,
  output logic [QUEUE_QUANTITY-1:0]               paused,
  output logic [ERR_CNT_BITS-1:0]                 err_cnt
);

  localparam int VCW = $clog2(QUEUE_QUANTITY);
  localparam int DW  = BUF_WIDTH + 1;

  // Handshake: a source word for VC i transfers on a rising edge where
  // src_valid[i] & src_ready[i] & enb; src_ready[i] depends only on the slot register.
  logic [QUEUE_QUANTITY-1:0] hold_vld_q, hold_vld_d;
  logic [DW-1:0]             hold_data_q [QUEUE_QUANTITY];
  logic [DW-1:0]             hold_data_d [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] paused_q, paused_d;
  logic [VCW-1:0]            ptr_q, ptr_d;
  logic                      push_q, push_d;
  logic [VCW-1:0]            vc_id_q, vc_id_d;
  logic [DW-1:0]             data_q, data_d;
  logic [ERR_CNT_BITS-1:0]   err_cnt_q, err_cnt_d;

  logic [QUEUE_QUANTITY-1:0] elig;
  logic                      grant_vld;
  logic [VCW-1:0]            grant_idx;
  logic [VCW-1:0]            cand;

  // Same-cycle pausa/error_full mask the candidate; the registered latch covers later cycles.
  always_comb begin
    elig      = hold_vld_q & ~paused_q & ~pausa & ~error_full;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
      cand = ptr_q + VCW'(k);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    paused_d    = paused_q;
    ptr_d       = ptr_q;
    push_d      = 1'b0;
    vc_id_d     = vc_id_q;
    data_d      = data_q;
    err_cnt_d   = err_cnt_q;
    if (enb) begin
      if (grant_vld) begin
        push_d                = 1'b1;
        vc_id_d               = grant_idx;
        data_d                = hold_data_q[grant_idx];
        hold_vld_d[grant_idx] = 1'b0;
        ptr_d                 = grant_idx;
      end
      // A granted slot is never ready in the same cycle, so capture cannot collide with it.
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        if (src_valid[i] && !hold_vld_q[i]) begin
          hold_vld_d[i]  = 1'b1;
          hold_data_d[i] = src_data[i*DW +: DW];
        end
      end
      paused_d = (paused_q & ~continuar) | pausa;
      if (|error_full && err_cnt_q != {ERR_CNT_BITS{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= '0;
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        hold_data_q[i] <= '0;
      end
      paused_q  <= '0;
      ptr_q     <= VCW'(QUEUE_QUANTITY - 1);
      push_q    <= 1'b0;
      vc_id_q   <= '0;
      data_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      paused_q    <= paused_d;
      ptr_q       <= ptr_d;
      push_q      <= push_d;
      vc_id_q     <= vc_id_d;
      data_q      <= data_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign src_ready = ~hold_vld_q;
  assign push      = push_q;
  assign vc_id     = vc_id_q;
  assign data_word = data_q;
  assign paused    = paused_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ingreso_vc.sv
// Randomised and directed bench for ingreso_vc with a queue-based reference model
// and a decoupled monitor that checks every emitted word against an expected queue.
module tb_ingreso_vc;

  logic        clk;
  logic        rst;
  logic        enb;
  logic [3:0]  src_valid;
  logic [15:0] src_data;
  logic [3:0]  src_ready;
  logic [3:0]  pausa;
  logic [3:0]  continuar;
  logic [3:0]  error_full;
  logic        push;
  logic [1:0]  vc_id;
  logic [3:0]  data_word;
  logic [3:0]  paused;
  logic [7:0]  err_cnt;

  ingreso_vc #(
    .QUEUE_QUANTITY(4),
    .BUF_WIDTH     (3),
    .ERR_CNT_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .pausa     (pausa),
    .continuar (continuar),
    .error_full(error_full),
    .push      (push),
    .vc_id     (vc_id),
    .data_word (data_word),
    .paused    (paused),
    .err_cnt   (err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // reference model: pending words per VC, pause flags, last-served VC, error count
  logic [3:0] m_held    = '0;
  logic [3:0] m_word [4];
  logic [3:0] m_paused  = '0;
  int         m_ptr     = 3;
  bit         m_push    = 1'b0;
  int         m_last_vc = 0;
  logic [3:0] m_last_data = '0;
  int         m_err     = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] old_held;
    int g;
    int c;
    if (rst) begin
      m_held = '0; m_paused = '0; m_ptr = 3; m_push = 1'b0;
      m_last_vc = 0; m_last_data = '0; m_err = 0;
      exp_q.delete();
    end else if (enb) begin
      old_held = m_held;
      g = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (g < 0 && m_held[c] && !m_paused[c] && !pausa[c] && !error_full[c]) g = c;
      end
      if (g >= 0) begin
        exp_q.push_back({2'(g), m_word[g]});
        m_push = 1'b1;
        m_last_vc = g;
        m_last_data = m_word[g];
        m_held[g] = 1'b0;
        m_ptr = g;
      end else begin
        m_push = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (src_valid[i] && !old_held[i]) begin
          m_held[i] = 1'b1;
          m_word[i] = src_data[i*4 +: 4];
        end
      end
      m_paused = (m_paused & ~continuar) | pausa;
      if (|error_full && m_err < 255) m_err++;
    end else begin
      m_push = 1'b0;
    end
  endtask

  // driver: apply one cycle of inputs at negedge, advance the model at posedge
  task automatic drive(input logic r, input logic e, input logic [3:0] v, input logic [15:0] d,
                       input logic [3:0] pa, input logic [3:0] co, input logic [3:0] er);
    @(negedge clk);
    rst = r; enb = e; src_valid = v; src_data = d;
    pausa = pa; continuar = co; error_full = er;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 4'h0, 16'h0, 4'h0, 4'h0, 4'h0);
  endtask

  function automatic logic [3:0] rnd_bits(input int one_in);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, one_in - 1) == 0);
    return r;
  endfunction

  // scoreboard monitor
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("push", {31'd0, push}, {31'd0, m_push});
        if (push === 1'b1) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_push: got vc %0d data %0d expected no word at %0t",
                     vc_id, data_word, $time);
          end else begin
            e = exp_q.pop_front();
            check("push_vc", {30'd0, vc_id}, {30'd0, e[5:4]});
            check("push_data", {28'd0, data_word}, {28'd0, e[3:0]});
          end
        end
        check("vc_id_hold", {30'd0, vc_id}, m_last_vc);
        check("data_hold", {28'd0, data_word}, {28'd0, m_last_data});
        check("src_ready", {28'd0, src_ready}, {28'd0, ~m_held});
        check("paused", {28'd0, paused}, {28'd0, m_paused});
        check("err_cnt", {24'd0, err_cnt}, m_err);
      end
    end
  end

  initial begin
    rst = 1'b1; enb = 1'b0; src_valid = '0; src_data = '0;
    pausa = '0; continuar = '0; error_full = '0;

    // reset, two cycles
    drive(1'b1, 1'b1, 4'h0, 16'h0, 4'h0, 4'h0, 4'h0);
    drive(1'b1, 1'b1, 4'h0, 16'h0, 4'h0, 4'h0, 4'h0);
    #1;
    check("rst_push", {31'd0, push}, 32'd0);
    check("rst_vc_id", {30'd0, vc_id}, 32'd0);
    check("rst_data", {28'd0, data_word}, 32'd0);
    check("rst_src_ready", {28'd0, src_ready}, 32'hf);
    check("rst_paused", {28'd0, paused}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    mon_en = 1'b1;

    // single word on VC0
    drive(1'b0, 1'b1, 4'b0001, 16'h0008, 4'h0, 4'h0, 4'h0);
    idle(3);

    // round-robin across all VCs, then reload VC1 after it is served
    drive(1'b0, 1'b1, 4'hf, {4'd14, 4'd3, 4'd2, 4'd5}, 4'h0, 4'h0, 4'h0);
    idle(2);
    drive(1'b0, 1'b1, 4'b0010, 16'h0090, 4'h0, 4'h0, 4'h0);
    idle(5);

    // pause VC2, load VC1 and VC2, then resume VC2
    drive(1'b0, 1'b1, 4'h0, 16'h0, 4'b0100, 4'h0, 4'h0);
    drive(1'b0, 1'b1, 4'b0110, {4'd0, 4'd4, 4'd10, 4'd0}, 4'h0, 4'h0, 4'h0);
    idle(3);
    drive(1'b0, 1'b1, 4'h0, 16'h0, 4'h0, 4'b0100, 4'h0);
    idle(2);

    // simultaneous pausa/continuar on VC3, then same-cycle pausa blocking VC0
    drive(1'b0, 1'b1, 4'b1000, 16'h7000, 4'b1000, 4'b1000, 4'h0);
    idle(2);
    drive(1'b0, 1'b1, 4'h0, 16'h0, 4'h0, 4'b1000, 4'h0);
    drive(1'b0, 1'b1, 4'b0001, 16'h0001, 4'h0, 4'h0, 4'h0);
    drive(1'b0, 1'b1, 4'h0, 16'h0, 4'b0001, 4'h0, 4'h0);
    drive(1'b0, 1'b1, 4'h0, 16'h0, 4'h0, 4'b0001, 4'h0);
    idle(2);

    // error_full on VC1 for three cycles
    drive(1'b0, 1'b1, 4'b0010, 16'h0060, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'h0, 16'h0, 4'h0, 4'h0, 4'b0010);
    idle(2);

    // enb low mid-burst with noisy inputs
    drive(1'b0, 1'b1, 4'hf, {4'd9, 4'd8, 4'd7, 4'd6}, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    idle(6);

    // randomised traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), 4'($urandom),
            16'($urandom), rnd_bits(16), rnd_bits(4), rnd_bits(16));
    end

    // long error_full run to reach saturation
    for (int i = 0; i < 270; i++) begin
      drive(1'b0, 1'b1, 4'($urandom), 16'($urandom), 4'h0, 4'hf, 4'b0001);
    end

    // drain everything still held
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 4'h0, 16'h0, 4'h0, 4'hf, 4'h0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    check("drained_ready", {28'd0, src_ready}, 32'hf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
